serial_cmp_arbiter: RTL and testbench

Shares one bit-serial magnitude-compare engine between two requesters. Each requester hands over a pair of WIDTH-bit operands with a valid/ready handshake. The block arbitrates round-robin and shifts the operands through the serial compare MSB-first, one bit per clock. It then presents a tagged greater/equal/less result on a valid/ready output port. It sits between operand producers and the serial comparator datapath, and is the sequencer that owns it.

---
 rtl/serial_cmp_arbiter.sv | 149 ++++++++++++++
 tb/tb_serial_cmp_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmp_arbiter.sv
// serial_cmp_arbiter: two-requester round-robin front end for a bit-serial
// unsigned magnitude comparator. The operands are shifted MSB-first, one bit per
// clock, and the result is returned as a tagged gt/eq/lt one-hot on a
// valid/ready port.
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN. When it is defined, the
// shift phase ends on the first differing bit instead of always running
// WIDTH cycles.
module serial_cmp_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic             res_gt,
  output logic             res_eq,
  output logic             res_lt,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] C_EQ = 2'd0;
  localparam logic [1:0] C_GT = 2'd1;
  localparam logic [1:0] C_LT = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cmp;
  logic             r_id;
  logic             r_last;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;

  logic             w_idle;
  logic             w_grant;
  logic             w_hs;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_differ;
  logic [1:0]       w_cmp_nxt;
  logic             w_exit;

  // The grant is only a proposal until the handshake. last_grant moves only when
  // a result is retired, so a requester that drops valid costs nothing.
  assign w_idle     = (r_state == S_IDLE) && !reset;
  assign w_grant    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid && w_grant;
  assign w_hs       = req0_ready || req1_ready;
  assign w_sel_a    = w_grant ? req1_a : req0_a;
  assign w_sel_b    = w_grant ? req1_b : req0_b;
  assign w_differ   = r_sa[WIDTH-1] ^ r_sb[WIDTH-1];

  // Next compare verdict: the first differing bit decides, and the verdict then sticks.
  always_comb begin
    w_cmp_nxt = r_cmp;
    if (r_cmp == C_EQ && w_differ)
      w_cmp_nxt = r_sa[WIDTH-1] ? C_GT : C_LT;
  end

  // Shift phase termination: last bit consumed, or (optionally) verdict known.
  always_comb begin
    w_exit = (r_cnt == CNT_W'(1));
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    if (r_cmp == C_EQ && w_differ)
      w_exit = 1'b1;
`else
    w_exit = w_exit;
`endif
  end

  // Sequencer state, arbitration history and the registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cmp   <= C_EQ;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_gt    <= 1'b0;
      r_eq    <= 1'b1;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_state <= S_SHIFT;
            r_cnt   <= CNT_W'(WIDTH);
            r_cmp   <= C_EQ;
            r_id    <= w_grant;
          end
        end
        S_SHIFT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          r_cmp <= w_cmp_nxt;
          if (w_exit) begin
            r_state <= S_DONE;
            r_gt    <= (w_cmp_nxt == C_GT);
            r_eq    <= (w_cmp_nxt == C_EQ);
            r_lt    <= (w_cmp_nxt == C_LT);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_last  <= r_id;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand shift registers: load on the handshake, then move MSB-first during the shift phase.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_sa <= w_sel_a;
      r_sb <= w_sel_b;
    end else if (r_state == S_SHIFT) begin
      r_sa <= {r_sa[WIDTH-2:0], 1'b0};
      r_sb <= {r_sb[WIDTH-2:0], 1'b0};
    end
  end

  assign res_valid = (r_state == S_DONE);
  assign res_id    = r_id;
  assign res_gt    = r_gt;
  assign res_eq    = r_eq;
  assign res_lt    = r_lt;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_cmp_arbiter.sv
// Directed bench for serial_cmp_arbiter (WIDTH=8). It uses a vector table for
// single operations, plus hand sequences for arbitration order, backpressure and
// reset abort. Expected latencies follow SERIAL_CMP_EARLY_EXIT_EN when that macro is defined.
module tb_serial_cmp_arbiter;
  localparam int WIDTH = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             res_valid, res_ready, res_id, res_gt, res_eq, res_lt, busy;

  always #5 clk = ~clk;

  serial_cmp_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_gt(res_gt), .res_eq(res_eq), .res_lt(res_lt), .busy(busy)
  );

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic       gt;
    logic       eq;
    logic       lt;
    int         lat_full;
    int         lat_early;
  } vec_t;

  vec_t tbl[12];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply one table vector from an idle negedge and check handshake, latency and result.
  task automatic run_vec(input int idx);
    vec_t v;
    int   lat;
    v = tbl[idx];
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b;
    end else begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b;
    end
    #1;
    check($sformatf("v%0d ready0", idx), 32'(req0_ready), 32'(v.id == 1'b0));
    check($sformatf("v%0d ready1", idx), 32'(req1_ready), 32'(v.id == 1'b1));
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(EARLY ? v.lat_early : v.lat_full));
    check($sformatf("v%0d gt", idx), 32'(res_gt), 32'(v.gt));
    check($sformatf("v%0d eq", idx), 32'(res_eq), 32'(v.eq));
    check($sformatf("v%0d lt", idx), 32'(res_lt), 32'(v.lt));
    check($sformatf("v%0d id", idx), 32'(res_id), 32'(v.id));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check($sformatf("v%0d retired", idx), 32'(res_valid), 32'd0);
    check($sformatf("v%0d idle", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    int lat;
    logic exp_id;

    tbl[0]  = '{1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 8, 1};
    tbl[1]  = '{1'b1, 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 8, 8};
    tbl[2]  = '{1'b1, 8'h3C, 8'h3D, 1'b0, 1'b0, 1'b1, 8, 8};
    tbl[3]  = '{1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 8, 1};
    tbl[4]  = '{1'b1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 8, 1};
    tbl[5]  = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 8, 1};
    tbl[6]  = '{1'b0, 8'h40, 8'h60, 1'b0, 1'b0, 1'b1, 8, 3};
    tbl[7]  = '{1'b1, 8'hF0, 8'hE0, 1'b1, 1'b0, 1'b0, 8, 4};
    tbl[8]  = '{1'b0, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b1, 8, 1};
    tbl[9]  = '{1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8, 8};
    tbl[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8, 8};
    tbl[11] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 8, 8};

    // Reset values, with both requesters already valid.
    reset = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h5A;
    req1_valid = 1'b1; req1_a = 8'h3C; req1_b = 8'h3D;
    @(negedge clk);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_id", 32'(res_id), 32'd0);
    check("rst res_gt", 32'(res_gt), 32'd0);
    check("rst res_eq", 32'(res_eq), 32'd1);
    check("rst res_lt", 32'(res_lt), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready0", 32'(req0_ready), 32'd0);
    check("rst ready1", 32'(req1_ready), 32'd0);

    // Continuous contention from reset: grants alternate 0,1,0,1 with no idle gap.
    res_ready = 1'b1;
    reset = 1'b0;
    #1;
    for (int op = 0; op < 4; op++) begin
      exp_id = op[0];
      w = 0;
      while (!(req0_ready || req1_ready) && w < 30) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("rr%0d gap", op), 32'(w), (op == 0) ? 32'd0 : 32'd1);
      check($sformatf("rr%0d ready0", op), 32'(req0_ready), 32'(exp_id == 1'b0));
      check($sformatf("rr%0d ready1", op), 32'(req1_ready), 32'(exp_id == 1'b1));
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end while (!res_valid && lat < 20);
      check($sformatf("rr%0d latency", op), 32'(lat - 1),
            (exp_id == 1'b0 && EARLY) ? 32'd1 : 32'd8);
      check($sformatf("rr%0d id", op), 32'(res_id), 32'(exp_id));
      check($sformatf("rr%0d gt", op), 32'(res_gt), 32'(exp_id == 1'b0));
      check($sformatf("rr%0d lt", op), 32'(res_lt), 32'(exp_id == 1'b1));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    check("rr drain busy", 32'(busy), 32'd0);

    // Backpressure: result held for 5 cycles, then the next handshake is available one cycle after retire.
    req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h3D;
    #1;
    check("bp ready0", 32'(req0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp latency", 32'(lat), 32'd8);
    req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h00;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d valid", k), 32'(res_valid), 32'd1);
      check($sformatf("bp%0d lt", k), 32'(res_lt), 32'd1);
      check($sformatf("bp%0d eq", k), 32'(res_eq), 32'd0);
      check($sformatf("bp%0d id", k), 32'(res_id), 32'd0);
      check($sformatf("bp%0d busy", k), 32'(busy), 32'd1);
      check($sformatf("bp%0d ready0", k), 32'(req0_ready), 32'd0);
      check($sformatf("bp%0d ready1", k), 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check("bp next ready1", 32'(req1_ready), 32'd1);
    req1_valid = 1'b0;
    #1;
    check("bp drop ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check("bp drop busy", 32'(busy), 32'd0);

    // Reset in the 4th shift cycle aborts the operation; afterwards, requester 0 wins the tie.
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h00;
    #1;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort busy before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort res_valid", 32'(res_valid), 32'd0);
    check("abort res_eq", 32'(res_eq), 32'd1);
    check("abort res_gt", 32'(res_gt), 32'd0);
    check("abort res_lt", 32'(res_lt), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort tie ready0", 32'(req0_ready), 32'd1);
    check("abort tie ready1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("abort idle", 32'(busy), 32'd0);

    // Table of single operations.
    for (int i = 0; i < 12; i++)
      run_vec(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
